// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, line-level bit constants, parity helper.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // ones_odd is the XOR-reduction of the payload; odd parity inverts it.
  function automatic logic parity_bit(input logic ones_odd, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Holds the accepted word and parity type; parity output follows the held copy.
// Loads on the acceptance edge, so parity is valid from the start-bit cycle onward.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  par_typ_in,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  par_bit_o
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  par_typ_d, par_typ_q;

  always_comb begin
    data_d    = data_q;
    par_typ_d = par_typ_q;
    if (load) begin
      data_d    = data_in;
      par_typ_d = par_typ_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      par_typ_q <= PAR_EVEN;
    end else begin
      data_q    <= data_d;
      par_typ_q <= par_typ_d;
    end
  end

  assign data_o    = data_q;
  assign par_bit_o = parity_bit(^data_q, par_typ_q);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one bit per clock: start, data LSB-first, optional parity, stop.
// Frame starts the edge after acceptance; Busy high for the whole frame, requests while busy are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  tx_if
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_d, state_q;
  logic [CNT_W-1:0]      bit_cnt_d, bit_cnt_q;
  logic                  par_en_d, par_en_q;
  logic                  tx_out_d, tx_out_q;
  logic                  busy_d, busy_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_held;
  logic                  par_bit;

  assign accept = (state_q == IDLE) && tx_if.Data_Valid;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (accept),
    .data_in    (tx_if.P_DATA),
    .par_typ_in (tx_if.PAR_TYP),
    .data_o     (data_held),
    .par_bit_o  (par_bit)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          bit_cnt_d = '0;
          par_en_d  = tx_if.PAR_EN;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    tx_out_d = STOP_BIT;
    busy_d   = 1'b1;
    case (state_d)
      IDLE:    busy_d   = 1'b0;
      START:   tx_out_d = START_BIT;
      DATA:    tx_out_d = data_held[bit_cnt_d];
      PARITY:  tx_out_d = par_bit;
      STOP:    tx_out_d = STOP_BIT;
      default: busy_d   = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      tx_out_q  <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_if.TX_OUT = tx_out_q;
  assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus random traffic against a queue-based line model.
module tb_uart_tx;

  logic clk;
  logic rst_n;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK   (clk),
    .RST   (rst_n),
    .tx_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Line model: an accepted word becomes a queue of line bits, one popped per clock.
  bit        m_q[$];
  logic      m_tx   = 1'b1;
  logic      m_busy = 1'b0;
  int        exp_len = 0;
  int        run     = 0;
  logic [15:0] obs_vec;
  int        obs_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic pen, input logic ptyp);
    m_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_q.push_back(d[i]);
    if (pen) m_q.push_back((($countones(d) % 2) != 0) ^ ptyp);
    m_q.push_back(1'b1);
    exp_len = pen ? 11 : 10;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (!m_busy && bus.Data_Valid)
        model_accept(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
      if (m_q.size() > 0) begin
        m_tx   = m_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
    #1;
    chk("tx_out", bus.TX_OUT, m_tx);
    chk("busy", bus.Busy, m_busy);
    if (bus.Busy) begin
      if (obs_n < 16) obs_vec[obs_n] = bus.TX_OUT;
      obs_n++;
      run++;
    end else if (run != 0) begin
      chk("busy_len", run, exp_len);
      run = 0;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic [15:0] exp_vec, input int exp_n);
    obs_vec = '0;
    obs_n   = 0;
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    repeat (12) step();
    chk("frame_bits", obs_vec, exp_vec);
    chk("frame_len", obs_n, exp_n);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    obs_vec        = '0;
    obs_n          = 0;

    #12;
    chk("reset_tx", bus.TX_OUT, 1'b1);
    chk("reset_busy", bus.Busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Reset asserted while D3 is on the line
    bus.P_DATA     = 8'h5A;
    bus.PAR_EN     = 1'b1;
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", bus.TX_OUT, 1'b1);
    chk("midrst_busy", bus.Busy, 1'b0);
    m_q.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
    run    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Expected vectors: bit i is the i-th line bit after acceptance
    run_frame(8'hA5, 1'b1, 1'b0, 16'd1354, 11);
    run_frame(8'hA5, 1'b1, 1'b1, 16'd1866, 11);
    run_frame(8'h3C, 1'b0, 1'b0, 16'd632, 10);

    // Request during a frame in flight must be dropped
    obs_vec = '0;
    obs_n   = 0;
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    repeat (3) step();
    bus.P_DATA     = 8'hFF;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b1;
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    repeat (8) step();
    chk("ignore_bits", obs_vec, 16'd632);
    chk("ignore_len", obs_n, 10);
    repeat (5) step();

    // Valid held high: back-to-back frames with one idle bit between
    obs_vec = '0;
    obs_n   = 0;
    bus.PAR_EN     = 1'b0;
    bus.P_DATA     = 8'h01;
    bus.Data_Valid = 1'b1;
    step();
    bus.P_DATA = 8'h80;
    repeat (20) step();
    bus.Data_Valid = 1'b0;
    repeat (5) step();
    chk("b2b_busy_bits", obs_n, 20);

    for (int n = 0; n < 400; n++) begin
      bus.Data_Valid = ($urandom_range(0, 3) == 0);
      bus.P_DATA     = 8'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);
      step();
    end
    bus.Data_Valid = 1'b0;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts a parallel data word with a one-cycle valid strobe and serializes it as start bit, data LSB-first, optional parity bit and stop bit on a single line. It is the transmit counterpart of the oversampling UART receiver path and runs in the UART clock domain. TX clock equals the baud rate, so one bit is emitted per clock. `Busy` is exported so the upstream FIFO/synchronizer holds the next word.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK` input 1: UART TX clock, one bit period per cycle; all logic on rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `P_DATA` input DATA_WIDTH: parallel word to send, sampled only on acceptance.
- `Data_Valid` input 1: request strobe; accepted only when `Busy`=0.
- `PAR_EN` input 1: 1 = insert parity bit; sampled on acceptance.
- `PAR_TYP` input 1: 0 = even, 1 = odd parity; sampled on acceptance.
- `TX_OUT` output 1: serial line, registered, idles high.
- `Busy` output 1: registered, high for every cycle a frame bit is on `TX_OUT`.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `Busy`=0. On an edge with `Data_Valid`=1, latch `P_DATA`, `PAR_EN`, `PAR_TYP` into internal registers and go to START.
- START: `TX_OUT`=0, `Busy`=1, bit counter cleared. Next state DATA.
- DATA: `TX_OUT`=latched data[bit_cnt], LSB first; counter increments each cycle. After bit DATA_WIDTH-1 go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: `TX_OUT` = ^data when PAR_TYP=0 (even: total ones including parity even); ~^data when PAR_TYP=1. Next state STOP.
- STOP: `TX_OUT`=1, `Busy`=1. Next state IDLE.
- `Data_Valid` while `Busy`=1 is ignored; nothing is queued. `P_DATA`/`PAR_*` changes mid-frame have no effect.
- Parity is computed from the latched word, not the live input.
- Bit counter width $clog2(DATA_WIDTH); it never wraps inside a frame, it is cleared in START.

## Timing
- Reset (async assert, any state, including mid-frame): state IDLE, `TX_OUT`=1, `Busy`=0, counter 0, latched data 0. The frame is abandoned; the line returns high immediately.
- Acceptance at edge E0. After E0: start bit, `Busy`=1. After E1..E8: D0..D7 (DATA_WIDTH=8).
- Parity enabled: parity after E9, stop after E10, IDLE after E11. 11 `Busy` cycles.
- Parity disabled: stop after E9, IDLE after E10. 10 `Busy` cycles.
- The first IDLE cycle after a frame can accept the next word: minimum one idle-high bit between frames.
- `Data_Valid` held high continuously produces frames separated by exactly one idle bit.
- `TX_OUT` and `Busy` are driven directly from flops. No combinational path exists from inputs to outputs.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE/START/DATA/PARITY/STOP), constants START_BIT=0, STOP_BIT=1, PAR_EVEN=0, PAR_ODD=1, default DATA_WIDTH.
- Sub-module `uart_tx_parity_calc`: latches the word and parity type on acceptance and outputs the parity bit.
- FSM, bit counter and output mux stay in `uart_tx`.

## Test plan
- Reset mid-frame: assert `RST` low during DATA bit 3 -> `TX_OUT`=1 and `Busy`=0 immediately. After release, a new `Data_Valid` starts a clean frame.
- `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0, one-cycle `Data_Valid` -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1. `Busy` high exactly 11 cycles.
- `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=1 -> identical except parity bit = 1.
- `P_DATA`=8'h3C, `PAR_EN`=0 -> 0,0,0,1,1,1,1,0,0,1. `Busy` high 10 cycles, no parity slot.
- `Data_Valid` pulsed with 8'hFF during a frame in flight -> ignored. The current frame is unchanged and no second frame follows.
- `Data_Valid` held high with `P_DATA` 8'h01 then 8'h80 -> two frames, each correctly serialized, with exactly one idle-high cycle between stop bit and next start bit.
